// File: rtl/avalon_bus_router.sv
// Single-master data bus router: decodes a device-select field onto NSLV slave ports,
// runs each transaction through IDLE/ACCESS/RESP/RELEASE, with watchdog and error counter.
module avalon_bus_router #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 16,
   parameter int unsigned SEL_LO  = 12,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned NSLV    = 3,
   parameter int unsigned SAW     = 12,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ECW     = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               ReadData,
   input  logic               WriteData,
   input  logic [AW-1:0]      DataAddr,
   input  logic [DW-1:0]      BusIn,
   output logic [DW-1:0]      BusOut,
   output logic               DataDone,
   output logic               BusError,
   output logic [ECW-1:0]     ErrCount,
   output logic [NSLV-1:0]    SlvRead,
   output logic [NSLV-1:0]    SlvWrite,
   output logic [SAW-1:0]     SlvAddr,
   output logic [DW-1:0]      SlvWdata,
   input  logic [NSLV*DW-1:0] SlvRdata,
   input  logic [NSLV-1:0]    SlvDone
);

   localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WdLast = WDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StResp, StRelease} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             write_q, write_d;
   logic             err_q, err_d;
   logic [WDW-1:0]   wdog_q, wdog_d;
   logic [DW-1:0]    bus_out_q, bus_out_d;
   logic [ECW-1:0]   err_cnt_q, err_cnt_d;
   logic [NSLV-1:0]  slv_read_q, slv_read_d;
   logic [NSLV-1:0]  slv_write_q, slv_write_d;
   logic [SAW-1:0]   slv_addr_q, slv_addr_d;
   logic [DW-1:0]    slv_wdata_q, slv_wdata_d;

   logic             req;
   logic [SEL_W-1:0] req_idx;
   logic             req_mapped;
   logic [NSLV-1:0]  req_onehot;
   logic             sel_done;
   logic [DW-1:0]    sel_rdata;
   logic             wdog_expired;
   logic             err_inc;

   assign req          = ReadData | WriteData;
   assign req_idx      = DataAddr[SEL_LO +: SEL_W];
   assign req_mapped   = 32'(req_idx) < NSLV;
   assign wdog_expired = (TIMEOUT != 0) && (wdog_q == WdLast);

   // Only the selected slave's done/rdata are ever looked at.
   always_comb begin
      req_onehot = '0;
      sel_done   = 1'b0;
      sel_rdata  = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         req_onehot[i] = (req_idx == SEL_W'(i));
         if (sel_q == SEL_W'(i)) begin
            sel_done  = SlvDone[i];
            sel_rdata = SlvRdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      write_d     = write_q;
      err_d       = err_q;
      wdog_d      = wdog_q;
      bus_out_d   = bus_out_q;
      err_cnt_d   = err_cnt_q;
      slv_read_d  = slv_read_q;
      slv_write_d = slv_write_q;
      slv_addr_d  = slv_addr_q;
      slv_wdata_d = slv_wdata_q;
      err_inc     = 1'b0;

      case (state_q)
         StIdle: begin
            if (req) begin
               sel_d       = req_idx;
               write_d     = WriteData;
               slv_addr_d  = DataAddr[SAW-1:0];
               slv_wdata_d = BusIn;
               wdog_d      = '0;
               if (req_mapped) begin
                  state_d     = StAccess;
                  err_d       = 1'b0;
                  slv_read_d  = WriteData ? '0 : req_onehot;
                  slv_write_d = WriteData ? req_onehot : '0;
               end else begin
                  state_d   = StResp;
                  err_d     = 1'b1;
                  bus_out_d = '0;
                  err_inc   = 1'b1;
               end
            end
         end
         StAccess: begin
            wdog_d = wdog_q + WDW'(1);
            if (!req) begin
               // Master gave up: no response phase, nothing counted.
               state_d     = StIdle;
               slv_read_d  = '0;
               slv_write_d = '0;
            end else if (sel_done) begin
               state_d     = StResp;
               err_d       = 1'b0;
               slv_read_d  = '0;
               slv_write_d = '0;
               if (!write_q) bus_out_d = sel_rdata;
            end else if (wdog_expired) begin
               state_d     = StResp;
               err_d       = 1'b1;
               slv_read_d  = '0;
               slv_write_d = '0;
               bus_out_d   = '0;
               err_inc     = 1'b1;
            end
         end
         StResp:    state_d = StRelease;
         StRelease: if (!req) state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      // Counted on entry to RESP so ErrCount already reflects the error while BusError is shown.
      if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ECW'(1);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         wdog_q      <= '0;
         bus_out_q   <= '0;
         err_cnt_q   <= '0;
         slv_read_q  <= '0;
         slv_write_q <= '0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         write_q     <= write_d;
         err_q       <= err_d;
         wdog_q      <= wdog_d;
         bus_out_q   <= bus_out_d;
         err_cnt_q   <= err_cnt_d;
         slv_read_q  <= slv_read_d;
         slv_write_q <= slv_write_d;
         slv_addr_q  <= slv_addr_d;
         slv_wdata_q <= slv_wdata_d;
      end
   end

   assign BusOut   = bus_out_q;
   assign DataDone = (state_q == StResp);
   assign BusError = (state_q == StResp) && err_q;
   assign ErrCount = err_cnt_q;
   assign SlvRead  = slv_read_q;
   assign SlvWrite = slv_write_q;
   assign SlvAddr  = slv_addr_q;
   assign SlvWdata = slv_wdata_q;

endmodule

// File: tb/tb_avalon_bus_router.sv
// Randomised transaction bench for avalon_bus_router: a schedule-level model predicts every
// cycle's outputs; directed cases pin the model with literal expectations.
module tb_avalon_bus_router;

   localparam int DW    = 16;
   localparam int NSLV  = 3;
   localparam int TO    = 4;
   localparam int ECW   = 2;
   localparam int ECMAX = (1 << ECW) - 1;

   logic              Clock, Reset, ReadData, WriteData;
   logic [15:0]       DataAddr, BusIn, BusOut, SlvWdata;
   logic              DataDone, BusError;
   logic [ECW-1:0]    ErrCount;
   logic [NSLV-1:0]   SlvRead, SlvWrite, SlvDone;
   logic [11:0]       SlvAddr;
   logic [NSLV*DW-1:0] SlvRdata;

   avalon_bus_router #(
      .DW(16), .AW(16), .SEL_LO(12), .SEL_W(4), .NSLV(NSLV), .SAW(12),
      .TIMEOUT(TO), .ECW(ECW)
   ) dut (
      .Clock(Clock), .Reset(Reset), .ReadData(ReadData), .WriteData(WriteData),
      .DataAddr(DataAddr), .BusIn(BusIn), .BusOut(BusOut), .DataDone(DataDone),
      .BusError(BusError), .ErrCount(ErrCount), .SlvRead(SlvRead), .SlvWrite(SlvWrite),
      .SlvAddr(SlvAddr), .SlvWdata(SlvWdata), .SlvRdata(SlvRdata), .SlvDone(SlvDone)
   );

   always #5 Clock = ~Clock;

   int vectors = 0;
   int miscompares = 0;
   logic chk_en = 1'b0;

   // Model state: expected outputs for the current cycle.
   logic [NSLV-1:0] exp_rd, exp_wr;
   logic            exp_done, exp_err;
   logic [15:0]     m_bo, m_wdata;
   logic [11:0]     m_addr;
   int              m_ec;

   // Observation counters for directed checks.
   int rd_cnt[NSLV], wr_cnt[NSLV];
   int done_cnt = 0, berr_cnt = 0;
   int s_rd[NSLV], s_wr[NSLV];
   int s_done, s_berr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (chk_en) begin
         check("SlvRead", 32'(SlvRead), 32'(exp_rd));
         check("SlvWrite", 32'(SlvWrite), 32'(exp_wr));
         check("DataDone", 32'(DataDone), 32'(exp_done));
         check("BusError", 32'(BusError), 32'(exp_err));
         check("BusOut", 32'(BusOut), 32'(m_bo));
         check("ErrCount", 32'(ErrCount), 32'(m_ec));
         check("SlvAddr", 32'(SlvAddr), 32'(m_addr));
         check("SlvWdata", 32'(SlvWdata), 32'(m_wdata));
      end
      if (!Reset) begin
         for (int i = 0; i < NSLV; i++) begin
            if (SlvRead[i]) rd_cnt[i]++;
            if (SlvWrite[i]) wr_cnt[i]++;
         end
         if (DataDone) done_cnt++;
         if (DataDone && BusError) berr_cnt++;
      end
   end

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_exp();
      exp_rd = '0; exp_wr = '0; exp_done = 1'b0; exp_err = 1'b0;
   endtask

   task automatic model_reset();
      idle_exp();
      m_bo = '0; m_ec = 0; m_addr = '0; m_wdata = '0;
   endtask

   // Random rdata everywhere and random done on every slave except sel.
   task automatic drive_noise(input int sel);
      for (int i = 0; i < NSLV; i++) begin
         SlvDone[i] = (i == sel) ? 1'b0 : 1'($urandom_range(0, 1));
         SlvRdata[i*DW +: DW] = 16'($urandom);
      end
   endtask

   task automatic snap();
      s_rd = rd_cnt; s_wr = wr_cnt; s_done = done_cnt; s_berr = berr_cnt;
   endtask

   task automatic do_reset();
      ReadData = 1'b0; WriteData = 1'b0;
      model_reset();
      Reset = 1'b1;
      next_cycle();
      Reset = 1'b0;
   endtask

   // One master transaction. lat: wait cycles before the slave's done;
   // abort_at: ACCESS cycle in which the master drops its request (0 = never);
   // hold: extra cycles the request stays high after DataDone.
   task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input int abort_at,
                          input int hold, input logic [15:0] rdata);
      int idx, n;
      logic err;
      logic [NSLV-1:0] oh;
      idx = int'(addr[15:12]);
      oh = (idx < NSLV) ? NSLV'(1 << idx) : '0;
      ReadData = rd; WriteData = wr; DataAddr = addr; BusIn = wdata;
      idle_exp(); drive_noise(-1);
      next_cycle();
      m_addr = addr[11:0]; m_wdata = wdata;
      if (idx >= NSLV) begin
         n = 0; err = 1'b1;
      end else begin
         err = (abort_at == 0) && (lat + 1 > TO);
         n = (abort_at != 0) ? abort_at : (err ? TO : lat + 1);
      end
      for (int j = 1; j <= n; j++) begin
         exp_rd = wr ? '0 : oh; exp_wr = wr ? oh : '0; exp_done = 1'b0; exp_err = 1'b0;
         drive_noise(idx);
         if (abort_at == 0 && j == lat + 1) begin
            SlvDone[idx] = 1'b1;
            SlvRdata[idx*DW +: DW] = rdata;
         end
         if (abort_at != 0 && j == abort_at) begin
            ReadData = 1'b0; WriteData = 1'b0;
         end
         next_cycle();
      end
      if (abort_at != 0 && idx < NSLV) begin
         idle_exp(); drive_noise(-1);
         return;
      end
      exp_rd = '0; exp_wr = '0; exp_done = 1'b1; exp_err = err;
      if (err) begin
         m_bo = '0;
         m_ec = (m_ec < ECMAX) ? m_ec + 1 : ECMAX;
      end else if (!wr) begin
         m_bo = rdata;
      end
      drive_noise(-1);
      next_cycle();
      for (int h = 0; h < hold; h++) begin
         idle_exp(); drive_noise(-1); next_cycle();
      end
      ReadData = 1'b0; WriteData = 1'b0;
      idle_exp(); drive_noise(-1);
      next_cycle();
      idle_exp(); drive_noise(-1);
   endtask

   initial begin
      Clock = 1'b0; Reset = 1'b1; ReadData = 1'b0; WriteData = 1'b0;
      DataAddr = '0; BusIn = '0; SlvDone = '0; SlvRdata = '0;
      for (int i = 0; i < NSLV; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; end
      model_reset();
      #3;
      check("reset_BusOut", 32'(BusOut), 32'h0);
      check("reset_DataDone", 32'(DataDone), 32'h0);
      check("reset_BusError", 32'(BusError), 32'h0);
      check("reset_ErrCount", 32'(ErrCount), 32'h0);
      check("reset_strobes", 32'({SlvRead, SlvWrite}), 32'h0);
      check("reset_SlvAddr", 32'(SlvAddr), 32'h0);
      next_cycle();
      Reset = 1'b0;
      chk_en = 1'b1;

      // Zero-wait write to slave 0, request held after completion.
      snap();
      run_txn(1'b0, 1'b1, 16'h0005, 16'h1234, 0, 0, 3, 16'h0);
      check("wr_slv0_cycles", 32'(wr_cnt[0] - s_wr[0]), 32'd1);
      check("wr_done_count", 32'(done_cnt - s_done), 32'd1);
      check("wr_SlvAddr", 32'(SlvAddr), 32'h005);
      check("wr_SlvWdata", 32'(SlvWdata), 32'h1234);

      // Read slave 1 with 3 waits: done lands on the last watchdog cycle and still wins.
      snap();
      run_txn(1'b1, 1'b0, 16'h1010, 16'h0, 3, 0, 0, 16'hBEEF);
      check("rd_slv1_cycles", 32'(rd_cnt[1] - s_rd[1]), 32'd4);
      check("rd_BusOut", 32'(BusOut), 32'hBEEF);
      check("rd_no_error", 32'(berr_cnt - s_berr), 32'd0);

      // Unmapped index 7.
      snap();
      run_txn(1'b1, 1'b0, 16'h7000, 16'h0, 0, 0, 1, 16'h0);
      check("unmapped_ErrCount", 32'(ErrCount), 32'd1);
      check("unmapped_BusOut", 32'(BusOut), 32'h0);
      check("unmapped_berr", 32'(berr_cnt - s_berr), 32'd1);
      check("unmapped_strobes", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] - s_rd[0] - s_rd[1]
                                     - s_rd[2]), 32'd0);

      // Slave 2 never answers.
      snap();
      run_txn(1'b1, 1'b0, 16'h2000, 16'h0, 50, 0, 0, 16'h0);
      check("timeout_slv2_cycles", 32'(rd_cnt[2] - s_rd[2]), 32'd4);
      check("timeout_berr", 32'(berr_cnt - s_berr), 32'd1);
      check("timeout_ErrCount", 32'(ErrCount), 32'd2);

      // Master abort after two ACCESS cycles.
      snap();
      run_txn(1'b1, 1'b0, 16'h0010, 16'h0, 50, 2, 0, 16'h0);
      check("abort_slv0_cycles", 32'(rd_cnt[0] - s_rd[0]), 32'd2);
      check("abort_no_done", 32'(done_cnt - s_done), 32'd0);

      // Asynchronous reset while in ACCESS.
      ReadData = 1'b1; WriteData = 1'b0; DataAddr = 16'h2ABC; BusIn = 16'h5555;
      idle_exp(); drive_noise(-1);
      next_cycle();
      m_addr = 12'hABC; m_wdata = 16'h5555;
      exp_rd = 3'b100; drive_noise(2);
      #2;
      check("pre_reset_SlvRead", 32'(SlvRead), 32'h4);
      model_reset();
      Reset = 1'b1;
      #1;
      check("async_reset_SlvRead", 32'(SlvRead), 32'h0);
      check("async_reset_ErrCount", 32'(ErrCount), 32'h0);
      check("async_reset_DataDone", 32'(DataDone), 32'h0);
      ReadData = 1'b0;
      next_cycle();
      Reset = 1'b0;

      // Five errors saturate a 2-bit counter.
      for (int k = 0; k < 5; k++) begin
         run_txn(1'b1, 1'b0, 16'hF123, 16'h0, 0, 0, 0, 16'h0);
         if (k == 0) check("sat_first", 32'(ErrCount), 32'd1);
      end
      check("sat_ErrCount", 32'(ErrCount), 32'd3);

      // Random traffic.
      for (int t = 0; t < 300; t++) begin
         int op, idx, lat, ab, hold;
         if (t % 100 == 0) do_reset();
         op  = $urandom_range(0, 2);
         idx = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 15) : $urandom_range(0, 2);
         lat = $urandom_range(0, 6);
         ab  = 0;
         if (idx < NSLV && lat >= 1 && $urandom_range(0, 9) == 0)
            ab = $urandom_range(1, (lat < TO - 1) ? lat : TO - 1);
         hold = $urandom_range(0, 3);
         run_txn(1'(op != 1), 1'(op != 0), {4'(idx), 12'($urandom)}, 16'($urandom), lat, ab,
                 hold, 16'($urandom));
      end

      next_cycle();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
